// File: rtl/imu_bias_calibrator_pkg.sv
// Shared types and constants for the IMU bias calibrator.
// Optional deadband feature: IMU_DEADBAND_EN.
package imu_pkg;

   localparam int IMU_W = 16;

   localparam logic signed [IMU_W-1:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [IMU_W-1:0] SAT_MIN = 16'sh8000;

   typedef enum logic {
      S_CALIB = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   // Clamp a 17-bit signed difference into 16-bit signed range.
   function automatic logic signed [IMU_W-1:0] sat16(input logic signed [IMU_W:0] v);
      logic signed [IMU_W-1:0] r;
      if (v[IMU_W] != v[IMU_W-1])
         r = v[IMU_W] ? SAT_MIN : SAT_MAX;
      else
         r = v[IMU_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/imu_bias_calibrator_gyro_bias_axis.sv
// One gyro axis: bias accumulator, bias register and corrected output.
// Optional deadband on the corrected value: IMU_DEADBAND_EN.
module gyro_bias_axis
   import imu_pkg::*;
#(
   parameter int CALIB_LOG2 = 6,
   parameter int DEADBAND   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IMU_W-1:0]  sample,
   input  logic              acc_en,
   input  logic              latch_bias,
   input  logic              clear,
   input  logic              out_en,
   output logic [IMU_W-1:0]  gyro_out
);

   localparam int ACC_W = IMU_W + CALIB_LOG2;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] acc_avg;
   logic signed [IMU_W-1:0] bias;
   logic signed [IMU_W:0]   diff;
   logic signed [IMU_W-1:0] corr;
   logic signed [IMU_W-1:0] corr_out;

   // Running sum including the current sample, averaged by flooring shift.
   always_comb begin
      acc_sum = acc + $signed({{CALIB_LOG2{sample[IMU_W-1]}}, sample});
      acc_avg = acc_sum >>> CALIB_LOG2;
   end

   // Bias-corrected, saturated (and optionally deadbanded) sample.
   always_comb begin
      diff     = $signed({sample[IMU_W-1], sample}) - $signed({bias[IMU_W-1], bias});
      corr     = sat16(diff);
      corr_out = corr;
`ifdef IMU_DEADBAND_EN
      if ((int'(corr) >= -DEADBAND) && (int'(corr) <= DEADBAND))
         corr_out = '0;
`endif
   end

   // Accumulator and bias register; clear (recalibration) has top priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         bias <= '0;
      end else if (clear) begin
         acc  <= '0;
      end else if (latch_bias) begin
         bias <= acc_avg[IMU_W-1:0];
         acc  <= '0;
      end else if (acc_en) begin
         acc  <= acc_sum;
      end
   end

   // Registered corrected output, held between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         gyro_out <= '0;
      else if (out_en)
         gyro_out <= corr_out;
   end

endmodule

// File: rtl/imu_bias_calibrator.sv
// IMU bias calibrator top: calibration FSM, sample counter, accel
// pass-through and strobes. Optional gyro deadband: IMU_DEADBAND_EN.
module imu_bias_calibrator
   import imu_pkg::*;
#(
   parameter int CALIB_LOG2 = 6,
   parameter int DEADBAND   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] in_accel_x,
   input  logic [15:0] in_accel_y,
   input  logic [15:0] in_accel_z,
   input  logic [15:0] in_gyro_x,
   input  logic [15:0] in_gyro_y,
   input  logic [15:0] in_gyro_z,
   input  logic        recal,
   output logic [15:0] accel_x,
   output logic [15:0] accel_y,
   output logic [15:0] accel_z,
   output logic [15:0] gyro_x,
   output logic [15:0] gyro_y,
   output logic [15:0] gyro_z,
   output logic        out_valid,
   output logic        calib_done
);

   localparam logic [CALIB_LOG2-1:0] CNT_MAX = '1;

   state_t                  state;
   state_t                  state_nx;
   logic [CALIB_LOG2-1:0]   sample_cnt;
   logic                    acc_en;
   logic                    latch_bias;
   logic                    clear;
   logic                    out_en;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_CALIB;
      else
         state <= state_nx;
   end

   // Next state and per-axis controls; recal overrides any sample.
   always_comb begin
      state_nx   = state;
      acc_en     = 1'b0;
      latch_bias = 1'b0;
      clear      = 1'b0;
      out_en     = 1'b0;
      if (recal) begin
         state_nx = S_CALIB;
         clear    = 1'b1;
      end else begin
         case (state)
            S_CALIB: begin
               if (in_valid) begin
                  acc_en = 1'b1;
                  if (sample_cnt == CNT_MAX) begin
                     latch_bias = 1'b1;
                     state_nx   = S_RUN;
                  end
               end
            end
            S_RUN: begin
               out_en = in_valid;
            end
            default: state_nx = S_CALIB;
         endcase
      end
   end

   // Calibration sample counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sample_cnt <= '0;
      else if (clear || latch_bias)
         sample_cnt <= '0;
      else if (acc_en)
         sample_cnt <= sample_cnt + 1'b1;
   end

   // Status and output strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         calib_done <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         calib_done <= (state_nx == S_RUN);
         out_valid  <= out_en;
      end
   end

   // Accel pass-through, held between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accel_x <= '0;
         accel_y <= '0;
         accel_z <= '0;
      end else if (out_en) begin
         accel_x <= in_accel_x;
         accel_y <= in_accel_y;
         accel_z <= in_accel_z;
      end
   end

   gyro_bias_axis #(.CALIB_LOG2(CALIB_LOG2), .DEADBAND(DEADBAND)) u_axis_x (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample     (in_gyro_x),
      .acc_en     (acc_en),
      .latch_bias (latch_bias),
      .clear      (clear),
      .out_en     (out_en),
      .gyro_out   (gyro_x)
   );

   gyro_bias_axis #(.CALIB_LOG2(CALIB_LOG2), .DEADBAND(DEADBAND)) u_axis_y (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample     (in_gyro_y),
      .acc_en     (acc_en),
      .latch_bias (latch_bias),
      .clear      (clear),
      .out_en     (out_en),
      .gyro_out   (gyro_y)
   );

   gyro_bias_axis #(.CALIB_LOG2(CALIB_LOG2), .DEADBAND(DEADBAND)) u_axis_z (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample     (in_gyro_z),
      .acc_en     (acc_en),
      .latch_bias (latch_bias),
      .clear      (clear),
      .out_en     (out_en),
      .gyro_out   (gyro_z)
   );

endmodule

// File: tb/tb_imu_bias_calibrator.sv
// Self-checking bench for imu_bias_calibrator: directed test-plan steps
// plus randomized traffic, checked against a behavioural model.
module tb_imu_bias_calibrator;

   localparam int CL2 = 6;
   localparam int N   = 1 << CL2;
   localparam int DB  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic recal = 1'b0;
   logic [15:0] in_ax = '0, in_ay = '0, in_az = '0;
   logic [15:0] in_gx = '0, in_gy = '0, in_gz = '0;
   logic signed [15:0] accel_x, accel_y, accel_z;
   logic signed [15:0] gyro_x, gyro_y, gyro_z;
   logic out_valid, calib_done;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Behavioural model: calibrating flag, collected sample count/sums,
   // bias, and the expected registered outputs.
   bit m_cal;
   int m_cnt;
   int m_sum[3];
   int m_bias[3];
   int e_g[3];
   int e_a[3];
   bit e_ov;
   bit e_done;

   always #5 clk = ~clk;

   imu_bias_calibrator #(.CALIB_LOG2(CL2), .DEADBAND(DB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_accel_x (in_ax),
      .in_accel_y (in_ay),
      .in_accel_z (in_az),
      .in_gyro_x  (in_gx),
      .in_gyro_y  (in_gy),
      .in_gyro_z  (in_gz),
      .recal      (recal),
      .accel_x    (accel_x),
      .accel_y    (accel_y),
      .accel_z    (accel_z),
      .gyro_x     (gyro_x),
      .gyro_y     (gyro_y),
      .gyro_z     (gyro_z),
      .out_valid  (out_valid),
      .calib_done (calib_done)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int floor_div(input int s, input int n);
      int q;
      q = s / n;
      if ((s % n != 0) && (s < 0)) q--;
      return q;
   endfunction

   function automatic int correct(input int g, input int b);
      int v;
      v = g - b;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`ifdef IMU_DEADBAND_EN
      if (v >= -DB && v <= DB) v = 0;
`endif
      return v;
   endfunction

   task automatic model_reset();
      m_cal = 1'b1;
      m_cnt = 0;
      e_ov = 1'b0;
      e_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_sum[i] = 0; m_bias[i] = 0; e_g[i] = 0; e_a[i] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ov"},   out_valid,  e_ov);
      chk({tag, ".done"}, calib_done, e_done);
      chk({tag, ".gx"},   gyro_x,  e_g[0]);
      chk({tag, ".gy"},   gyro_y,  e_g[1]);
      chk({tag, ".gz"},   gyro_z,  e_g[2]);
      chk({tag, ".ax"},   accel_x, e_a[0]);
      chk({tag, ".ay"},   accel_y, e_a[1]);
      chk({tag, ".az"},   accel_z, e_a[2]);
   endtask

   // One clock: drive at the falling edge, update the model, check at the
   // next falling edge.
   task automatic cyc(input bit v, input bit r, input int gx, input int gy, input int gz,
                      input int ax, input int ay, input int az);
      int g[3];
      int a[3];
      g = '{gx, gy, gz};
      a = '{ax, ay, az};
      in_valid = v; recal = r;
      in_gx = 16'(gx); in_gy = 16'(gy); in_gz = 16'(gz);
      in_ax = 16'(ax); in_ay = 16'(ay); in_az = 16'(az);
      e_ov = 1'b0;
      if (r) begin
         m_cal = 1'b1; m_cnt = 0; e_done = 1'b0;
         for (int i = 0; i < 3; i++) m_sum[i] = 0;
      end else if (m_cal) begin
         if (v) begin
            for (int i = 0; i < 3; i++) m_sum[i] += g[i];
            m_cnt++;
            if (m_cnt == N) begin
               for (int i = 0; i < 3; i++) begin
                  m_bias[i] = floor_div(m_sum[i], N);
                  m_sum[i] = 0;
               end
               m_cnt = 0; m_cal = 1'b0; e_done = 1'b1;
            end
         end
      end else if (v) begin
         e_ov = 1'b1;
         for (int i = 0; i < 3; i++) begin
            e_g[i] = correct(g[i], m_bias[i]);
            e_a[i] = a[i];
         end
      end
      @(negedge clk);
      in_valid = 1'b0; recal = 1'b0;
      check_all("cyc");
   endtask

   function automatic int rnd16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
   endtask

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Calibration and run.
      for (int i = 0; i < N; i++) begin
         cyc(1, 0, 10, -20, 300, rnd16(), rnd16(), rnd16());
         if (i < N - 1) chk("cal_done_low", calib_done, 0);
      end
      chk("cal_done_high", calib_done, 1);
      idle(2);
      cyc(1, 0, 15, -20, 290, 100, -5, 16384);
      chk("plan_gx", gyro_x, 5);
      chk("plan_gy", gyro_y, 0);
      chk("plan_gz", gyro_z, -10);
      chk("plan_az", accel_z, 16384);
      idle(1);
      chk("plan_ov_single", out_valid, 0);

      // Floor rounding.
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) cyc(1, 0, (i % 2 == 0) ? -1 : -2, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 2, 3);
      chk("floor_gx", gyro_x, 2);

      // Saturation both directions.
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) cyc(1, 0, -100, 100, 0, 0, 0, 0);
      cyc(1, 0, 32767, -32768, 0, 0, 0, 0);
      chk("sat_hi", gyro_x, 32767);
      chk("sat_lo", gyro_y, -32768);

      // Recal colliding with a sample in run.
      cyc(1, 1, 1, 2, 3, 4, 5, 6);
      chk("recal_ov", out_valid, 0);
      chk("recal_done", calib_done, 0);
      for (int i = 0; i < N; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 7, 7, 7, 9, 9, 9);
      chk("recal_gx", gyro_x, 7);

      // Deadband boundary values (bias is zero here).
      cyc(1, 0, 4, -4, 5, 0, 0, 0);
      cyc(1, 0, -5, 0, -4, 0, 0, 0);

      // Random calibration with gaps, mid-calibration recal, back-to-back run.
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 0, 0, 0, 0, 0, 0);
         for (int i = 0; i < 20; i++) cyc($urandom_range(0, 1), 0, rnd16(), rnd16(), rnd16(), 0, 0, 0);
         cyc(1, 1, rnd16(), rnd16(), rnd16(), 0, 0, 0);
         while (m_cal) cyc($urandom_range(0, 3) != 0, 0, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
         for (int i = 0; i < 40; i++)
            cyc($urandom_range(0, 4) != 0, 0, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
      end

      // Reset mid-calibration.
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 30; i++) cyc(1, 0, 50, 50, 50, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N - 1; i++) cyc(1, 0, 3, 3, 3, 1, 1, 1);
      chk("midreset_notdone", calib_done, 0);
      cyc(1, 0, 3, 3, 3, 1, 1, 1);
      chk("midreset_done", calib_done, 1);
      cyc(1, 0, 13, 3, -3, 1, 1, 1);
      chk("midreset_ov", out_valid, 1);
      idle(2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/imu_bias_calibrator.md
Name: imu_bias_calibrator

Overview:
- Sits directly downstream of the MPU SPI driver and consumes its six signed 16-bit samples plus the one-cycle `valid` strobe.
- After reset it averages 2^CALIB_LOG2 gyro samples to estimate the static gyro bias.
- It then streams bias-corrected, saturated gyro data, with accel passed through, to the Kalman filter stage.
- A recalibration request restarts bias estimation at any time.

Parameters:
- CALIB_LOG2, 6: log2 of the number of samples averaged per calibration (64 by default); legal range 1..10.
- DEADBAND, 4: gyro magnitude threshold used only when IMU_DEADBAND_EN is defined; unsigned, at most 32767.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle strobe; sample inputs are valid when high
- in_accel_x / in_accel_y / in_accel_z  in  16 each  signed accel samples
- in_gyro_x / in_gyro_y / in_gyro_z  in  16 each  signed gyro samples
- recal  in  1  one-cycle request to restart calibration
- accel_x / accel_y / accel_z  out  16 each  signed, registered accel pass-through
- gyro_x / gyro_y / gyro_z  out  16 each  signed, registered bias-corrected gyro
- out_valid  out  1  one-cycle strobe; outputs are valid when high
- calib_done  out  1  high while bias is valid (S_RUN)

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: state = S_CALIB; all outputs = 0; out_valid = 0; calib_done = 0; accumulators, sample counter and biases = 0.
- State S_CALIB:
  - On each in_valid, add each gyro axis (sign-extended) into an accumulator that is 16+CALIB_LOG2 bits wide, and increment sample_cnt (CALIB_LOG2 bits).
  - When in_valid arrives with sample_cnt = 2^CALIB_LOG2-1:
    - bias_axis <= (acc + sample) >>> CALIB_LOG2. This is an arithmetic shift, so it floors toward negative infinity; keep the low 16 bits.
    - Clear the accumulators and counter.
    - calib_done <= 1; go to S_RUN.
  - out_valid stays 0 throughout S_CALIB. Accel inputs are ignored.
- State S_RUN:
  - On in_valid, the next cycle must present:
    - gyro_axis = sat16(in_gyro - bias), computed in 17-bit signed and clamped to [-32768, 32767];
    - accel_axis = in_accel, unchanged;
    - out_valid = 1 for exactly one cycle.
  - Latency is 1 cycle. Outputs hold their last values between strobes.
  - Back-to-back in_valid on consecutive cycles must be accepted, producing consecutive out_valid pulses.
- recal, in any state:
  - Next cycle: state = S_CALIB, calib_done = 0, accumulators and counter cleared.
  - Bias registers keep their old value until the new calibration completes; they are not used while in S_CALIB.
  - recal together with in_valid in the same cycle: recal wins, and the sample is neither accumulated nor output (out_valid = 0).
  - recal arriving during S_CALIB restarts the count from 0.
- Reset mid-operation: asynchronous return to the reset values above, including any partial accumulation.
- Overflow: the accumulator width guarantees no overflow for 2^CALIB_LOG2 full-scale samples.

Optional Feature:
- Macro: IMU_DEADBAND_EN.
- Defined:
  - After saturation, any corrected gyro value v with |v| <= DEADBAND is output as 0. Compare v >= -DEADBAND and v <= DEADBAND.
  - Applied in the same cycle, so latency is unchanged.
  - Accel is unaffected.
- Undefined: no deadband logic; corrected gyro is output directly.

Decomposition:
- Package imu_pkg holds:
  - the state encodings S_CALIB and S_RUN;
  - the saturation limits SAT_MAX = 16'sh7FFF and SAT_MIN = 16'sh8000;
  - the sample width constant IMU_W = 16.
- Sub-module gyro_bias_axis, instantiated 3x, one per axis. It contains:
  - the accumulator and bias register;
  - the subtract/saturate stage and the optional deadband;
  - controls driven by the top FSM: acc_en, latch_bias, clear, out_en.
- The top level owns the FSM, sample counter, accel pass-through, out_valid and calib_done.

Test Plan:
- Calibration and run:
  - Stimulus: reset; 64 strobes with gyro = (10, -20, 300); then one strobe with gyro = (15, -20, 290) and accel = (100, -5, 16384).
  - Required: out_valid never high during the 64 calibration strobes; calib_done rises after the 64th strobe.
  - Required: one cycle after the final strobe, gyro = (5, 0, -10), accel = (100, -5, 16384), out_valid = 1 for a single cycle.
- Floor rounding: calibrate with gyro_x alternating -1/-2 (sum -96) -> bias_x = -2; then input 0 -> gyro_x = 2.
- Saturation:
  - Calibrate at gyro_x = -100; input 32767 -> gyro_x = 32767.
  - Calibrate at gyro_y = 100; input -32768 -> gyro_y = -32768.
- Recalibration:
  - In S_RUN, assert recal in the same cycle as in_valid -> no out_valid and calib_done = 0.
  - Then 64 strobes at gyro = 0 -> bias = 0; input (7, 7, 7) -> output (7, 7, 7).
- Reset mid-calibration: 30 strobes, then pulse rst_n low -> all outputs 0; a further 64 strobes are required before the first out_valid.
- Deadband (IMU_DEADBAND_EN, DEADBAND = 4):
  - Bias 0; inputs 4 -> 0, -4 -> 0, 5 -> 5, -5 -> -5.
  - Without the macro, 4 -> 4.
